// File: rtl/external_pin_pkg.sv
// Shared types and constants for the external pin monitor and its event FIFO.
// Holds the event record layout and the debounce counter width.
package external_pin_pkg;

   localparam int PIN_W = 32;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [PIN_W-1:0] value;
      logic [PIN_W-1:0] mask;
   } pin_event_t;

   // Terminal count for a debounce window of d stable cycles.
   function automatic logic [CNT_W-1:0] deb_last(input int unsigned d);
      return CNT_W'(d - 1);
   endfunction

endpackage

// File: rtl/external_pin_event_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is dropped unless
// a pop happens on the same edge; a pop on an empty FIFO is ignored.
module external_pin_event_fifo
   import external_pin_pkg::*;
#(
   parameter int DW    = 2 * PIN_W,
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          empty,
   output logic          full,
   output logic          drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      // A same-edge pop frees the slot the incoming push needs.
      do_push  = push && (!full || do_pop);
      drop     = push && !do_push;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      head     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/external_pin_monitor.sv
// Drives the pad-bound pin vector and turns asynchronous pin levels into queued,
// optionally debounced change events. Debounce is built when EXTERNAL_PIN_MONITOR_DEBOUNCE_EN is defined.
module external_pin_monitor
   import external_pin_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEBOUNCE = 4,
   parameter int DEPTH    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_in,
   input  logic             write__ENA,
   input  logic [WIDTH-1:0] write_v,
   output logic             write__RDY,
   output logic             event__RDY,
   input  logic             event__ENA,
   output logic [WIDTH-1:0] event_value,
   output logic [WIDTH-1:0] event_mask,
   output logic [WIDTH-1:0] level,
   output logic             overflow,
   input  logic             clearOverflow__ENA
);

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic [WIDTH-1:0] mask;
   } mon_event_t;

   if (DEBOUNCE < 1 || DEBOUNCE > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("external_pin_monitor: DEBOUNCE must be 1..255 and DEPTH a power of two >= 2");
   end

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] pin_in_q, pin_in_d;
   logic             overflow_q, overflow_d;
   logic             push;
   logic             fifo_empty, fifo_full, fifo_drop;
   mon_event_t       push_evt, head_evt;

`ifdef EXTERNAL_PIN_MONITOR_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] DEB_LAST = deb_last(DEBOUNCE);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Stability is judged on s1 vs s2 (s2 about to change), so acceptance lands
   // exactly DEBOUNCE edges after s2 settles on a new value.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      push    = 1'b0;
      if (s2_q == level_q || s1_q != s2_q) begin
         cnt_d = '0;
      end else if (cnt_q == DEB_LAST) begin
         level_d = s2_q;
         cnt_d   = '0;
         push    = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   always_comb begin
      level_d = s2_q;
      push    = (s2_q != level_q);
   end
`endif

   always_comb begin
      s1_d          = pin_out;
      s2_d          = s1_q;
      pin_in_d      = write__ENA ? write_v : pin_in_q;
      push_evt.value = s2_q;
      push_evt.mask  = s2_q ^ level_q;
      // Set wins over a coincident clear so a drop is never lost.
      overflow_d    = clearOverflow__ENA ? 1'b0 : overflow_q;
      if (fifo_drop) overflow_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q       <= '0;
         s2_q       <= '0;
         level_q    <= '0;
         pin_in_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         level_q    <= level_d;
         pin_in_q   <= pin_in_d;
         overflow_q <= overflow_d;
      end
   end

   external_pin_event_fifo #(
      .DW    (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push),
      .push_data (push_evt),
      .pop       (event__ENA),
      .head      (head_evt),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .drop      (fifo_drop)
   );

   assign pin_in      = pin_in_q;
   assign level       = level_q;
   assign overflow    = overflow_q;
   assign write__RDY  = ~RST;
   assign event__RDY  = ~fifo_empty;
   assign event_value = head_evt.value;
   assign event_mask  = head_evt.mask;

endmodule
